// File: rtl/cnn_window_gen.sv
// ---------------------------------------------------------------------------
// cnn_window_gen
//
// Streaming KY x KX window generator for the CNN core. Accepts one raster-scan
// pixel per valid cycle for an IW x IH single-channel feature map, keeps the
// previous KY-1 rows in line buffers and, for every pixel that completes a
// full window (valid-mode, stride 1), emits the packed window with a one-cycle
// valid pulse one cycle after the pixel is accepted.
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset
//   i_soft_reset   synchronous clear, wins over every other input
//   i_pixel_valid  pixel present this cycle (always accepted, no backpressure)
//   i_pixel        pixel value
//   o_win_valid    one-cycle pulse, o_win_FM holds a complete window
//   o_win_FM       packed window; element (ky,kx) at [(ky*KX+kx)*BIT_IN_F +: BIT_IN_F],
//                  ky=0 oldest row, kx=0 oldest column; holds while o_win_valid=0
//   o_frame_done   one-cycle pulse after the last pixel of a frame
//   o_busy         frame in progress
//
// State table
//   state  | meaning
//   IDLE   | no frame in progress; next accepted pixel is (0,0)
//   ACTIVE | pixel (0,0) accepted, last pixel of the frame not yet accepted
// ---------------------------------------------------------------------------
module cnn_window_gen #(
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int BIT_IN_F = 8,
  parameter int IW       = 8,
  parameter int IH       = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_soft_reset,
  input  logic                         i_pixel_valid,
  input  logic [BIT_IN_F-1:0]          i_pixel,
  output logic                         o_win_valid,
  output logic [BIT_IN_F*KY*KX-1:0]    o_win_FM,
  output logic                         o_frame_done,
  output logic                         o_busy
);

  localparam int CW  = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW  = (IH > 1) ? $clog2(IH) : 1;
  localparam int WW  = BIT_IN_F * KY * KX;
  localparam int NLB = (KY > 1) ? KY - 1 : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;

  // Line buffer 0 holds the most recent completed row, NLB-1 the oldest.
  logic [BIT_IN_F-1:0] line_buf [NLB][IW];
  logic [BIT_IN_F-1:0] win      [KY][KX];
  logic [BIT_IN_F-1:0] col_vec  [KY];
  logic [WW-1:0]       win_next_flat;

  logic accept;
  logic col_last;
  logic row_last;
  logic frame_last;
  logic at_origin;
  logic trigger;

  // A pixel presented together with soft reset is discarded.
  assign accept     = i_pixel_valid && !i_soft_reset;
  assign col_last   = (col == CW'(IW - 1));
  assign row_last   = (row == RW'(IH - 1));
  assign frame_last = col_last && row_last;
  assign at_origin  = (col == '0) && (row == '0);
  // Depends only on the counters, so stale line-buffer data from an earlier
  // (or aborted) frame is never part of an emitted window.
  assign trigger    = (row >= RW'(KY - 1)) && (col >= CW'(KX - 1));

  // Column entering the window: oldest row at index 0, live pixel at KY-1.
  always_comb begin
    for (int ky = 0; ky < KY; ky++) begin
      col_vec[ky] = i_pixel;
    end
    for (int ky = 0; ky < KY - 1; ky++) begin
      col_vec[ky] = line_buf[KY-2-ky][col];
    end
  end

  // Window after this pixel's shift, already in the packed output order.
  always_comb begin
    win_next_flat = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX - 1; kx++) begin
        win_next_flat[(ky*KX+kx)*BIT_IN_F +: BIT_IN_F] = win[ky][kx+1];
      end
      win_next_flat[(ky*KX+KX-1)*BIT_IN_F +: BIT_IN_F] = col_vec[ky];
    end
  end

  // Data path storage: never cleared, only written by accepted pixels.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win[ky][kx] <= win_next_flat[(ky*KX+kx)*BIT_IN_F +: BIT_IN_F];
        end
      end
      line_buf[0][col] <= i_pixel;
      for (int k = 1; k < KY - 1; k++) begin
        line_buf[k][col] <= line_buf[k-1][col];
      end
    end
  end

  // Control: counters, FSM and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_FM     <= '0;
    end else if (i_soft_reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_FM     <= '0;
    end else begin
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_pixel_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (trigger) begin
          o_win_valid <= 1'b1;
          o_win_FM    <= win_next_flat;
        end
        o_frame_done <= frame_last;

        case (state)
          IDLE:    if (at_origin)  state <= ACTIVE;
          ACTIVE:  if (frame_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The FSM spends one cycle in IDLE between back-to-back frames; while a new
  // frame's first pixel is being presented in that cycle, keep busy asserted
  // so the port shows no gap.
  assign o_busy = (state == ACTIVE) || (o_frame_done && accept);

endmodule

// File: tb/tb_cnn_window_gen.sv
module tb_cnn_window_gen;

  localparam int KX = 3;
  localparam int KY = 3;
  localparam int BW = 8;
  localparam int WW = BW * KX * KY;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          v    [2];
  logic          s    [2];
  logic [BW-1:0] p    [2];
  logic          wv   [2];
  logic          fd   [2];
  logic          busy [2];
  logic [WW-1:0] fm   [2];

  cnn_window_gen #(.KX(KX), .KY(KY), .BIT_IN_F(BW), .IW(5), .IH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(s[0]), .i_pixel_valid(v[0]),
    .i_pixel(p[0]), .o_win_valid(wv[0]), .o_win_FM(fm[0]),
    .o_frame_done(fd[0]), .o_busy(busy[0]));

  cnn_window_gen #(.KX(KX), .KY(KY), .BIT_IN_F(BW), .IW(3), .IH(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(s[1]), .i_pixel_valid(v[1]),
    .i_pixel(p[1]), .o_win_valid(wv[1]), .o_win_FM(fm[1]),
    .o_frame_done(fd[1]), .o_busy(busy[1]));

  // Reference model: remembers the frame as an image and cuts windows out of it.
  int            iw [2] = '{5, 3};
  int            ih [2] = '{4, 3};
  int            pr [2];
  int            pc [2];
  bit            act [2];
  bit            e_wv [2];
  bit            e_fd [2];
  logic [WW-1:0] e_fm [2];
  logic [BW-1:0] img [2][8][8];

  int            obs_win  [2];
  int            obs_done [2];
  logic [WW-1:0] win_log  [2][$];

  int npass = 0;
  int ntot  = 0;

  localparam logic [WW-1:0] FIRST_A = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
  localparam logic [WW-1:0] FIRST_B = {8'hA2, 8'hA1, 8'hA0, 8'h92, 8'h91, 8'h90, 8'h82, 8'h81, 8'h80};

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear(input int d);
    pr[d] = 0; pc[d] = 0; act[d] = 0;
    e_wv[d] = 0; e_fd[d] = 0; e_fm[d] = '0;
  endtask

  task automatic model_edge(input int d);
    bit last;
    if (s[d]) begin
      model_clear(d);
    end else if (v[d]) begin
      img[d][pr[d]][pc[d]] = p[d];
      last = (pr[d] == ih[d] - 1) && (pc[d] == iw[d] - 1);
      e_wv[d] = (pr[d] >= KY - 1) && (pc[d] >= KX - 1);
      if (e_wv[d])
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            e_fm[d][(ky*KX+kx)*BW +: BW] = img[d][pr[d]-KY+1+ky][pc[d]-KX+1+kx];
      e_fd[d] = last;
      if (pr[d] == 0 && pc[d] == 0) act[d] = 1;
      if (last) act[d] = 0;
      if (pc[d] == iw[d] - 1) begin
        pc[d] = 0;
        pr[d] = (pr[d] == ih[d] - 1) ? 0 : pr[d] + 1;
      end else begin
        pc[d] = pc[d] + 1;
      end
    end else begin
      e_wv[d] = 0;
      e_fd[d] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already set; returns after the
  // next falling edge.
  task automatic cycle();
    bit eb;
    #1;
    for (int d = 0; d < 2; d++) begin
      // busy: a frame is in progress, or a new frame starts right at the boundary
      eb = act[d] || (e_fd[d] && v[d] && !s[d]);
      check($sformatf("busy%0d", d), WW'(busy[d]), WW'(eb));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("win_valid%0d", d), WW'(wv[d]), WW'(e_wv[d]));
      check($sformatf("frame_done%0d", d), WW'(fd[d]), WW'(e_fd[d]));
      check($sformatf("win_fm%0d", d), fm[d], e_fm[d]);
      if (wv[d] === 1'b1) begin
        obs_win[d]++;
        win_log[d].push_back(fm[d]);
      end
      if (fd[d] === 1'b1) begin
        obs_done[d]++;
        check($sformatf("done_with_win%0d", d), WW'(wv[d]), WW'(1'b1));
      end
    end
  endtask

  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      obs_win[d] = 0;
      obs_done[d] = 0;
      win_log[d].delete();
    end
  endtask

  task automatic drive_pix(input int d, input logic [BW-1:0] val, input logic srst);
    v[d] = 1'b1; p[d] = val; s[d] = srst;
    cycle();
    v[d] = 1'b0; s[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic frame(input int d, input int base, input int gap);
    for (int r = 0; r < ih[d]; r++)
      for (int c = 0; c < iw[d]; c++) begin
        drive_pix(d, BW'(base + r * 16 + c), 1'b0);
        idle(gap);
      end
  endtask

  task automatic soft_reset(input int d);
    s[d] = 1'b1;
    cycle();
    s[d] = 1'b0;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_win_valid%0d", d), WW'(wv[d]), '0);
      check($sformatf("rst_frame_done%0d", d), WW'(fd[d]), '0);
      check($sformatf("rst_busy%0d", d), WW'(busy[d]), '0);
      check($sformatf("rst_win_fm%0d", d), fm[d], '0);
      model_clear(d);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [WW-1:0] tmp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; s[d] = 1'b0; p[d] = '0;
      model_clear(d);
    end
    clr_counts();
    @(negedge clk);
    @(negedge clk);
    hard_reset();

    // 1. reset mid-run: a partial frame, then async reset; next pixel is (0,0)
    for (int i = 0; i < 7; i++) drive_pix(0, 8'hEE, 1'b0);
    hard_reset();
    clr_counts();

    // 2. continuous frame
    frame(0, 0, 0);
    idle(2);
    check("s2_windows", WW'(obs_win[0]), WW'(6));
    check("s2_done", WW'(obs_done[0]), WW'(1));
    check("s2_first", win_log[0][0], FIRST_A);
    tmp = win_log[0][5];
    check("s2_last_elem8", WW'(tmp[8*BW +: BW]), WW'(8'h34));

    // 3. gapped input
    clr_counts();
    frame(0, 0, 1);
    idle(2);
    check("s3_windows", WW'(obs_win[0]), WW'(6));
    check("s3_first", win_log[0][0], FIRST_A);

    // 4. soft reset mid-frame with a pixel in the same cycle
    clr_counts();
    for (int i = 0; i < 8; i++) drive_pix(0, BW'(8'h60 + i), 1'b0);
    drive_pix(0, 8'hFF, 1'b1);
    frame(0, 0, 0);
    idle(2);
    check("s4_windows", WW'(obs_win[0]), WW'(6));
    check("s4_first", win_log[0][0], FIRST_A);

    // 5. back-to-back frames
    clr_counts();
    frame(0, 0, 0);
    frame(0, 8'h80, 0);
    idle(2);
    check("s5_windows", WW'(obs_win[0]), WW'(12));
    check("s5_done", WW'(obs_done[0]), WW'(2));
    check("s5_b_first", win_log[0][6], FIRST_B);

    // soft reset coincident with the last pixel: no window, no frame_done
    clr_counts();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (r == 3 && c == 4) drive_pix(0, 8'h34, 1'b1);
        else if (r == 3 && c < 2) drive_pix(0, BW'(r * 16 + c), 1'b0);
        else if (r < 3) drive_pix(0, BW'(r * 16 + c), 1'b0);
        else drive_pix(0, BW'(r * 16 + c), 1'b0);
    idle(2);
    check("sr_last_windows", WW'(obs_win[0]), WW'(5));
    check("sr_last_done", WW'(obs_done[0]), WW'(0));
    clr_counts();
    frame(0, 0, 0);
    idle(1);
    check("sr_after_windows", WW'(obs_win[0]), WW'(6));

    // 6. minimum size 3x3
    clr_counts();
    frame(1, 0, 0);
    idle(2);
    check("s6_windows", WW'(obs_win[1]), WW'(1));
    check("s6_done", WW'(obs_done[1]), WW'(1));
    check("s6_window", win_log[1][0], FIRST_A);

    // randomized traffic on both instances, checked against the model each cycle
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        v[d] = ($urandom_range(0, 3) != 0);
        p[d] = BW'($urandom);
        s[d] = ($urandom_range(0, 59) == 0);
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; s[d] = 1'b0;
    end
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
